pc_stack: RTL and testbench
===========================

PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter SIZE, default 8, program counter width in bits (SIZE >= 2).
REQ-002 Parameter DEPTH, default 4, return-stack entries (DEPTH >= 1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 incr  input  1  step request: PC advances by 1.
REQ-006 jump  input  1  load PC with target.
REQ-007 branch  input  1  add offset to PC.
REQ-008 call  input  1  push return address and load PC with target.
REQ-009 ret  input  1  pop top of stack into PC.
REQ-010 target  input  SIZE  absolute address for jump/call.
REQ-011 offset  input  SIZE  two's-complement relative displacement for branch.
REQ-012 out  output  SIZE  current PC, registered.
REQ-013 depth  output  clog2(DEPTH+1)  number of valid stack entries.
REQ-014 full / empty  output  1 each  depth==DEPTH / depth==0, combinational from depth.
REQ-015 ovf / unf  output  1 each  sticky overflow / underflow flags.

Function
REQ-016 Command priority, highest first: jump, branch, call, ret, incr; exactly one command acts per cycle; lower-priority requests that cycle are discarded.
REQ-017 jump: out <= target next cycle; stack unchanged.
REQ-018 branch: out <= (out + offset) mod 2^SIZE; negative offsets wrap below 0.
REQ-019 call, not full: push (out + 1) mod 2^SIZE, depth += 1, out <= target.
REQ-020 call, full: out <= target, no push, depth unchanged, ovf <= 1.
REQ-021 ret, not empty: out <= top entry, depth -= 1.
REQ-022 ret, empty: out holds, unf <= 1.
REQ-023 incr (when accepted per REQ-031/032): out <= (out + 1) mod 2^SIZE; 2^SIZE-1 wraps to 0.
REQ-024 No command: out, stack and depth hold.
REQ-025 All effects visible one clock after the request edge; no combinational path from inputs to out.
REQ-026 ovf and unf remain 1 until reset.
REQ-027 Stack is LIFO; entries above depth are don't-care and never observable.

Reset
REQ-028 reset on a rising edge of clk: out <= 0, depth <= 0, ovf <= 0, unf <= 0, incr edge register <= 0.
REQ-029 reset overrides every command in the same cycle; stack contents need not be cleared.
REQ-030 No output changes between clock edges when reset is asserted.

Configuration
REQ-031 With macro PC_EDGE_DETECT_EN defined: incr is edge-detected; a step occurs only in a cycle where incr=1 and the registered previous incr=0; the register updates every cycle regardless of other commands.
REQ-032 Without PC_EDGE_DETECT_EN: incr is level-sensitive; one step in every cycle incr=1 and no higher-priority command is present; no edge register is built.

Verification
REQ-033 SIZE=8, reset, incr held high 5 cycles -> with PC_EDGE_DETECT_EN out=1; without it out=5.
REQ-034 out=0xFF, single accepted incr -> out=0x00; out=0x02, branch offset=0xFD -> out=0xFF.
REQ-035 DEPTH=4, out=0x10, call target=0x40 -> out=0x40, depth=1; ret -> out=0x11, depth=0.
REQ-036 Five calls in a row from reset -> depth=4, full=1, ovf=1, out=last target; four rets return the four pushed addresses in reverse order; fifth ret -> out holds, unf=1.
REQ-037 jump=1, branch=1, incr=1 same cycle, target=0x20 -> out=0x20; reset with call asserted mid-sequence -> out=0, depth=0, ovf=0, unf=0.

Source files
------------

// File: rtl/pc_stack.sv
// Program counter with jump/branch/call/return and a LIFO return-address stack.
// Optional macro PC_EDGE_DETECT_EN makes incr rising-edge triggered instead of level.
module pc_stack #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       incr,
    input  logic                       jump,
    input  logic                       branch,
    input  logic                       call,
    input  logic                       ret,
    input  logic [SIZE-1:0]            target,
    input  logic [SIZE-1:0]            offset,
    output logic [SIZE-1:0]            out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf
);
    localparam int DW = $clog2(DEPTH+1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] DMAX = DW'(DEPTH);

    // Storage rounded up to a power of two so the AW-bit index always fits.
    logic [SIZE-1:0] stk [(1<<AW)];
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    logic [DW-1:0]   depth_m1;
    logic            step;
    logic            do_push;

    assign full     = (depth == DMAX);
    assign empty    = (depth == '0);
    assign depth_m1 = depth - DW'(1);
    assign wr_idx   = depth[AW-1:0];
    assign rd_idx   = depth_m1[AW-1:0];
    assign do_push  = !reset && !jump && !branch && call && !full;

`ifdef PC_EDGE_DETECT_EN
    logic incr_q;

    always_ff @(posedge clk) begin
        if (reset) incr_q <= 1'b0;
        else       incr_q <= incr;
    end

    assign step = incr && !incr_q;
`else
    assign step = incr;
`endif

    always_ff @(posedge clk) begin
        if (do_push) stk[wr_idx] <= out + SIZE'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out   <= '0;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (jump) begin
            out <= target;
        end else if (branch) begin
            out <= out + offset;
        end else if (call) begin
            out <= target;
            if (full) ovf   <= 1'b1;
            else      depth <= depth + DW'(1);
        end else if (ret) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                out   <= stk[rd_idx];
                depth <= depth_m1;
            end
        end else if (step) begin
            out <= out + SIZE'(1);
        end
    end
endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack (SIZE=8, DEPTH=4) against a queue-based reference model.
module tb_pc_stack;
    logic       clk = 1'b0;
    logic       reset, incr, jump, branch, call, ret;
    logic [7:0] target, offset;
    logic [7:0] out;
    logic [2:0] depth;
    logic       full, empty, ovf, unf;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_pc;
    logic [7:0] m_stk[$];
    bit         m_ovf, m_unf, m_prev;

    pc_stack #(.SIZE(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .incr(incr), .jump(jump), .branch(branch),
        .call(call), .ret(ret), .target(target), .offset(offset), .out(out),
        .depth(depth), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // Drive one cycle of commands, advance the model, sample 1 time unit after the edge.
    task automatic cyc(input bit rs, input bit j, input bit b, input bit c, input bit r,
                       input bit i, input logic [7:0] t, input logic [7:0] o);
        bit         stepok;
        logic [7:0] ra;
        reset = rs; jump = j; branch = b; call = c; ret = r; incr = i;
        target = t; offset = o;
`ifdef PC_EDGE_DETECT_EN
        stepok = i && !m_prev;
`else
        stepok = i;
`endif
        if (rs) begin
            m_pc = 8'h00; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (j) begin
            m_pc = t;
        end else if (b) begin
            m_pc = m_pc + o;
        end else if (c) begin
            ra = m_pc + 8'd1;
            if (m_stk.size() < 4) m_stk.push_back(ra);
            else                  m_ovf = 1'b1;
            m_pc = t;
        end else if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_unf = 1'b1;
        end else if (stepok) begin
            m_pc = m_pc + 8'd1;
        end
        m_prev = rs ? 1'b0 : i;
        @(posedge clk);
        #1;
        reset = 0; jump = 0; branch = 0; call = 0; ret = 0; incr = 0;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        checks++;
        if ({out, depth, full, empty, ovf, unf} !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state out=%h depth=%0d full=%b empty=%b ovf=%b unf=%b", out, depth, full, empty, ovf, unf);
        end
    endtask

    task automatic test_incr_hold();
        logic [7:0] exp;
`ifdef PC_EDGE_DETECT_EN
        exp = 8'h01;
`else
        exp = 8'h05;
`endif
        cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        checks++;
        if (out !== exp) begin failures++; $display("FAIL incr_hold out=%h exp=%h", out, exp); end
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        checks++;
        if (out !== exp) begin failures++; $display("FAIL idle_hold out=%h exp=%h", out, exp); end
    endtask

    task automatic test_wrap();
        cyc(0, 1, 0, 0, 0, 0, 8'hFF, 8'h00);
        cyc(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        checks++;
        if (out !== 8'h00) begin failures++; $display("FAIL incr_wrap out=%h exp=00", out); end
        cyc(0, 1, 0, 0, 0, 0, 8'h02, 8'h00);
        cyc(0, 0, 1, 0, 0, 0, 8'h00, 8'hFD);
        checks++;
        if (out !== 8'hFF) begin failures++; $display("FAIL branch_neg out=%h exp=ff", out); end
    endtask

    task automatic test_call_ret();
        cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        cyc(0, 1, 0, 0, 0, 0, 8'h10, 8'h00);
        cyc(0, 0, 0, 1, 0, 0, 8'h40, 8'h00);
        checks++;
        if ({out, depth} !== {8'h40, 3'd1}) begin
            failures++; $display("FAIL call out=%h depth=%0d exp 40/1", out, depth);
        end
        cyc(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        checks++;
        if ({out, depth, empty} !== {8'h11, 3'd0, 1'b1}) begin
            failures++; $display("FAIL ret out=%h depth=%0d empty=%b exp 11/0/1", out, depth, empty);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_ret [4] = '{8'h31, 8'h21, 8'h11, 8'h01};
        cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int k = 1; k <= 5; k++) cyc(0, 0, 0, 1, 0, 0, 8'(k * 16), 8'h00);
        checks++;
        if ({out, depth, full, ovf, unf} !== {8'h50, 3'd4, 1'b1, 1'b1, 1'b0}) begin
            failures++; $display("FAIL overflow out=%h depth=%0d full=%b ovf=%b unf=%b", out, depth, full, ovf, unf);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
            checks++;
            if ({out, depth} !== {exp_ret[k], 3'(3 - k)}) begin
                failures++; $display("FAIL lifo_pop%0d out=%h depth=%0d exp %h/%0d", k, out, depth, exp_ret[k], 3 - k);
            end
        end
        cyc(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        checks++;
        if ({out, depth, unf, ovf} !== {8'h01, 3'd0, 1'b1, 1'b1}) begin
            failures++; $display("FAIL underflow out=%h depth=%0d unf=%b ovf=%b", out, depth, unf, ovf);
        end
    endtask

    task automatic test_priority();
        cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        cyc(0, 1, 1, 0, 0, 1, 8'h20, 8'h05);
        checks++;
        if (out !== 8'h20) begin failures++; $display("FAIL prio_jump out=%h exp=20", out); end
        cyc(0, 0, 1, 1, 1, 1, 8'h77, 8'h03);
        checks++;
        if ({out, depth} !== {8'h23, 3'd0}) begin failures++; $display("FAIL prio_branch out=%h depth=%0d exp 23/0", out, depth); end
        cyc(0, 0, 0, 1, 1, 1, 8'h60, 8'h00);
        cyc(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        cyc(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        cyc(0, 0, 0, 1, 0, 0, 8'h70, 8'h00);
        cyc(1, 0, 0, 1, 0, 1, 8'h90, 8'h00);
        checks++;
        if ({out, depth, ovf, unf} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL reset_over_call out=%h depth=%0d ovf=%b unf=%b", out, depth, ovf, unf);
        end
    endtask

    task automatic test_random();
        bit rs, j, b, c, r, i;
        for (int k = 0; k < 400; k++) begin
            rs = ($urandom_range(0, 59) == 0);
            j  = ($urandom_range(0, 9) == 0);
            b  = ($urandom_range(0, 7) == 0);
            c  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 3) == 0);
            i  = ($urandom_range(0, 1) == 0);
            cyc(rs, j, b, c, r, i, 8'($urandom), 8'($urandom));
            checks++;
            if ({out, depth, full, empty, ovf, unf} !==
                {m_pc, 3'(m_stk.size()), m_stk.size() == 4, m_stk.size() == 0, m_ovf, m_unf}) begin
                failures++;
                $display("FAIL random[%0d] got out=%h d=%0d f=%b e=%b o=%b u=%b exp out=%h d=%0d o=%b u=%b",
                         k, out, depth, full, empty, ovf, unf, m_pc, m_stk.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        reset = 1; incr = 0; jump = 0; branch = 0; call = 0; ret = 0;
        target = 0; offset = 0;
        m_pc = 0; m_ovf = 0; m_unf = 0; m_prev = 0;
        test_reset();
        test_incr_hold();
        test_wrap();
        test_call_ret();
        test_overflow();
        test_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
